uart_boot_loader: RTL

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/boot_pkg.sv | 21 ++
 rtl/uart_boot_loader_if.sv | 30 +++
 rtl/uart_boot_timer.sv | 29 ++
 rtl/uart_boot_loader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM states, default sync marker
// and frame field widths.
package boot_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DRAIN
    } boot_state_t;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte stream in from the UART receiver and word write bus out to memory.
interface uart_boot_loader_if;
    import boot_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        input  rx_data,
        input  rx_valid,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_ready
    );

endinterface

// File: rtl/uart_boot_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled, restarts on clear.
module uart_boot_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // A byte arriving in the same cycle as the limit wins over the timeout.
    assign expired = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed, XOR-checksummed image over UART and writes it to memory
// as little-endian 32-bit words starting at BASE_ADDR.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    uart_boot_loader_if.master bus,
    output logic               boot_busy,
    output logic               boot_done,
    output logic               boot_err
);

    boot_state_t       state;
    logic [LEN_W-1:0]  word_len;
    logic [LEN_W-1:0]  word_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_word;
    logic [BYTE_W-1:0] acc;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0] mem_wdata_q;
    logic              mem_we_q;

    logic tmr_enable;
    logic tmr_expired;

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

    assign tmr_enable = (state == LEN0) || (state == LEN1) ||
                        (state == DATA) || (state == CSUM);

    uart_boot_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (bus.rx_valid),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Every abort path (timeout, overrun, bad checksum) discards any pending
    // write so nothing is left in flight once we are back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_len    <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            asm_word    <= '0;
            acc         <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            boot_busy   <= 1'b0;
            boot_done   <= 1'b0;
            boot_err    <= 1'b0;
        end else begin
            boot_done <= 1'b0;

            if (mem_we_q && bus.mem_ready) begin
                mem_we_q   <= 1'b0;
                mem_addr_q <= mem_addr_q + 32'd4;
            end

            if (tmr_expired) begin
                boot_err  <= 1'b1;
                mem_we_q  <= 1'b0;
                state     <= IDLE;
                boot_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                            state      <= LEN0;
                            boot_busy  <= 1'b1;
                            boot_err   <= 1'b0;
                            acc        <= '0;
                            mem_addr_q <= BASE_ADDR;
                            byte_idx   <= '0;
                            word_cnt   <= '0;
                        end
                    end
                    LEN0: begin
                        if (bus.rx_valid) begin
                            word_len[7:0] <= bus.rx_data;
                            state         <= LEN1;
                        end
                    end
                    LEN1: begin
                        if (bus.rx_valid) begin
                            word_len[15:8] <= bus.rx_data;
                            if ({bus.rx_data, word_len[7:0]} == '0) begin
                                state <= CSUM;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (bus.rx_valid) begin
                            acc      <= acc ^ bus.rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                // Previous word still unaccepted: no room for this one.
                                if (mem_we_q && !bus.mem_ready) begin
                                    boot_err  <= 1'b1;
                                    mem_we_q  <= 1'b0;
                                    state     <= IDLE;
                                    boot_busy <= 1'b0;
                                end else begin
                                    mem_wdata_q <= {bus.rx_data, asm_word};
                                    mem_we_q    <= 1'b1;
                                    word_cnt    <= word_cnt + 16'd1;
                                    if (word_cnt + 16'd1 == word_len) begin
                                        state <= CSUM;
                                    end
                                end
                            end else begin
                                asm_word[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
                            end
                        end
                    end
                    CSUM: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == acc) begin
                                state <= DRAIN;
                            end else begin
                                boot_err  <= 1'b1;
                                mem_we_q  <= 1'b0;
                                state     <= IDLE;
                                boot_busy <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!mem_we_q) begin
                            boot_done <= 1'b1;
                            state     <= IDLE;
                            boot_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        boot_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
